hamming_encoder_stream: RTL and testbench

HAMMING_ENCODER_STREAM -- requirements
Module: hamming_encoder_stream

---
 rtl/hamming_encoder_stream.sv | 105 ++++++++++
 tb/tb_hamming_encoder_stream.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_encoder_stream.sv
// Streaming (16,11) SECDED Hamming encoder with a 2-entry output FIFO.
// Optional HAMMING_ERR_INJECT_EN adds inj_mask to flip stored codeword bits.
module hamming_encoder_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [16:1] code_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] words_sent,
    output logic        empty
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic [16:1] inj_mask
`endif
);

    logic [15:1] pos;
    logic        p1;
    logic        p2;
    logic        p4;
    logic        p8;
    logic        p16;
    logic [16:1] enc;
    logic [16:1] stored;

    logic [16:1] mem [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        started;
    logic        push;
    logic        pop;

    // Data bits occupy the non-power-of-two positions; parity slots stay 0.
    always_comb begin
        pos     = '0;
        pos[3]  = in_data[0];
        pos[5]  = in_data[1];
        pos[6]  = in_data[2];
        pos[7]  = in_data[3];
        pos[9]  = in_data[4];
        pos[10] = in_data[5];
        pos[11] = in_data[6];
        pos[12] = in_data[7];
        pos[13] = in_data[8];
        pos[14] = in_data[9];
        pos[15] = in_data[10];
    end

    assign p1  = pos[3] ^ pos[5] ^ pos[7] ^ pos[9]
               ^ pos[11] ^ pos[13] ^ pos[15];
    assign p2  = pos[3] ^ pos[6] ^ pos[7] ^ pos[10]
               ^ pos[11] ^ pos[14] ^ pos[15];
    assign p4  = pos[5] ^ pos[6] ^ pos[7] ^ pos[12]
               ^ pos[13] ^ pos[14] ^ pos[15];
    assign p8  = ^pos[15:9];
    assign p16 = p1 ^ p2 ^ p4 ^ p8 ^ (^pos);

    assign enc = {p16, pos[15:9], p8, pos[7:5], p4, pos[3], p2, p1};

`ifdef HAMMING_ERR_INJECT_EN
    assign stored = enc ^ inj_mask;
`else
    assign stored = enc;
`endif

    assign empty     = (count == 2'd0);
    assign out_valid = !empty;
    // started keeps in_ready low until the first edge after reset.
    assign in_ready  = started && (count != 2'd2);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign code_out  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            started    <= 1'b0;
            words_sent <= 16'h0000;
        end else begin
            started <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= stored;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr     <= ~rd_ptr;
                words_sent <= words_sent + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Self-checking bench for hamming_encoder_stream: vector table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_hamming_encoder_stream;

    logic        clk;
    logic        rst;
    logic [10:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [16:1] code_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] words_sent;
    logic        empty;
    logic [16:1] inj_mask;

    int checks;
    int errors;

    hamming_encoder_stream dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .code_out   (code_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .words_sent (words_sent),
        .empty      (empty)
`ifdef HAMMING_ERR_INJECT_EN
        ,
        .inj_mask   (inj_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] d;
        logic [15:0] c;
    } vec_t;

    vec_t        vecs [6];
    logic [16:1] q [$];
    logic [15:0] exp_ws;

    // Generic Hamming rule: data fills non-power-of-two slots in order,
    // parity 2^k covers every position with bit k set, bit 16 is overall.
    function automatic logic [16:1] ref_enc(input logic [10:0] d,
                                            input logic [16:1] mask);
        logic [16:1] c;
        int j;
        c = '0;
        j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            logic x;
            x = 1'b0;
            for (int p = 1; p <= 15; p++)
                if (p[k]) x = x ^ c[p];
            c[1 << k] = x;
        end
        c[16] = ^c[15:1];
        return c ^ mask;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        exp_ws = 16'h0000;
        q.delete();
        step();
    endtask

    initial begin
        logic [16:1] e;
        logic        mp;
        logic        mq;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        inj_mask = '0;
        exp_ws   = 16'h0000;

        vecs[0] = '{11'h000, 16'h0000};
        vecs[1] = '{11'h001, 16'h8007};
        vecs[2] = '{11'h7FF, 16'hFFFF};
        vecs[3] = '{11'h002, 16'h8019};
        vecs[4] = '{11'h400, 16'hC08B};
        vecs[5] = '{11'h010, 16'h8181};

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_words_sent", words_sent, 0);
        check("rst_code_out", code_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);

        // Table: accept one word, see it a cycle later, pop it.
        for (int i = 0; i < 6; i++) begin
            in_data   = vecs[i].d;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check("vec_valid", out_valid, 1);
            check("vec_code", code_out, vecs[i].c);
            step();
            exp_ws++;
            check("vec_empty", empty, 1);
            check("vec_ws", words_sent, exp_ws);
        end

        // Backpressure: third word stalls until the first pop.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'h001;
        step();
        in_data = 11'h7FF;
        step();
        in_data = 11'h002;
        check("bp_full_ready", in_ready, 0);
        step();
        check("bp_stall_ready", in_ready, 0);
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_code", code_out, 16'h8007);
        out_ready = 1'b1;
        step();
        exp_ws++;
        check("bp_second", code_out, 16'hFFFF);
        check("bp_ready_after_pop", in_ready, 1);
        step();
        exp_ws++;
        in_valid = 1'b0;
        check("bp_third", code_out, 16'h8019);
        step();
        exp_ws++;
        check("bp_drained", empty, 1);
        check("bp_ws", words_sent, exp_ws);

        // Occupancy 1 with simultaneous push and pop.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'h400;
        step();
        in_data   = 11'h010;
        out_ready = 1'b1;
        step();
        exp_ws++;
        in_valid = 1'b0;
        check("pp_valid", out_valid, 1);
        check("pp_ready", in_ready, 1);
        check("pp_code", code_out, 16'h8181);
        step();
        exp_ws++;
        check("pp_empty", empty, 1);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 2000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 11'($urandom);
`ifdef HAMMING_ERR_INJECT_EN
            inj_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
`endif
            #1;
            check("rnd_in_ready", in_ready, (q.size() < 2) ? 1 : 0);
            check("rnd_out_valid", out_valid, (q.size() > 0) ? 1 : 0);
            check("rnd_ws", words_sent, exp_ws);
            if (q.size() > 0) check("rnd_code", code_out, q[0]);
            mp = in_valid && (q.size() < 2);
            mq = out_ready && (q.size() > 0);
            e  = ref_enc(in_data, inj_mask);
            step();
            if (mq) begin
                void'(q.pop_front());
                exp_ws++;
            end
            if (mp) q.push_back(e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        inj_mask  = '0;
        for (int n = 0; n < 4 && q.size() > 0; n++) begin
            check("drain_code", code_out, q[0]);
            void'(q.pop_front());
            exp_ws++;
            step();
        end
        check("drain_empty", empty, 1);
        check("drain_ws", words_sent, exp_ws);

        // Counter wrap after 65535 deliveries.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 11'h123;
        step();
        for (int n = 0; n < 65534; n++) step();
        in_valid = 1'b0;
        step();
        check("wrap_ffff", words_sent, 16'hFFFF);
        check("wrap_empty", empty, 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("wrap_zero", words_sent, 16'h0000);

`ifdef HAMMING_ERR_INJECT_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'h001;
        inj_mask  = 16'h0004;
        step();
        in_valid = 1'b0;
        inj_mask = '0;
        check("inj_code", code_out, 16'h8003);
        out_ready = 1'b1;
        step();
`endif

        // Reset mid-stream with words buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'h001;
        step();
        in_data = 11'h7FF;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_ws", words_sent, 0);
        check("mid_rst_code", code_out, 0);
        step();
        rst = 1'b0;
        step();
        check("mid_rst_after_ready", in_ready, 1);
        check("mid_rst_after_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
